// File: rtl/mac_tile_dual_pkg.sv
// Shared types and constants for the dual-dataflow (WS/OS) systolic PE.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WS_RUN   = 2'd1,
        OS_RUN   = 2'd2,
        OS_DRAIN = 2'd3
    } state_e;

    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_DRAIN = 2;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_tile_dual_mac_unit.sv
// Combinational a*b+c with per-operand signedness and accumulator-range overflow detect.
// MAC_TILE_SAT_EN: clamp the result to the psum_bw range instead of wrapping.
module mac_unit
    import mac_pkg::*;
#(
    parameter int bw       = 4,
    parameter int psum_bw  = 16,
    parameter int A_SIGNED = 0,
    parameter int W_SIGNED = 1
) (
    input  logic [bw-1:0]      a_i,
    input  logic [bw-1:0]      b_i,
    input  logic [psum_bw-1:0] c_i,
    output logic [psum_bw-1:0] sum_o,
    output logic               ovf_o
);

    // Accumulator is two's complement whenever either operand may be negative.
    localparam bit ACC_SIGNED = (A_SIGNED != 0) || (W_SIGNED != 0);
    localparam int PW         = 2 * bw + 2;
    localparam int EW         = psum_bw + 2;

    logic                 a_top, b_top, c_top;
    logic signed [PW-1:0] a_x, b_x, prod;
    logic signed [EW-1:0] prod_x, c_x, sum_x;

    assign a_top  = (A_SIGNED != 0) & a_i[bw-1];
    assign b_top  = (W_SIGNED != 0) & b_i[bw-1];
    assign c_top  = ACC_SIGNED & c_i[psum_bw-1];

    assign a_x    = {{(PW - bw){a_top}}, a_i};
    assign b_x    = {{(PW - bw){b_top}}, b_i};
    assign prod   = a_x * b_x;

    assign prod_x = {{(EW - PW){prod[PW-1]}}, prod};
    assign c_x    = {{2{c_top}}, c_i};
    assign sum_x  = prod_x + c_x;

    generate
        if (ACC_SIGNED) begin : g_signed
            logic [2:0] top_bits;
            assign top_bits = sum_x[EW-1:psum_bw-1];
            assign ovf_o    = (|top_bits) & ~(&top_bits);
        end else begin : g_unsigned
            assign ovf_o = |sum_x[EW-1:psum_bw];
        end
    endgenerate

`ifdef MAC_TILE_SAT_EN
    localparam logic [psum_bw-1:0] SAT_MAX = ACC_SIGNED ? {1'b0, {(psum_bw-1){1'b1}}}
                                                        : {psum_bw{1'b1}};
    localparam logic [psum_bw-1:0] SAT_MIN = ACC_SIGNED ? {1'b1, {(psum_bw-1){1'b0}}}
                                                        : {psum_bw{1'b0}};
    always_comb begin
        sum_o = sum_x[psum_bw-1:0];
        if (ovf_o) begin
            sum_o = sum_x[EW-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_o = sum_x[psum_bw-1:0];
`endif

endmodule

// File: rtl/mac_tile_dual.sv
// Systolic PE running weight-stationary or output-stationary dataflow, chosen per tile.
// MAC_TILE_SAT_EN: saturating accumulator / WS psum instead of wrap-around.
module mac_tile_dual
    import mac_pkg::*;
#(
    parameter int bw       = 4,
    parameter int psum_bw  = 16,
    parameter int A_SIGNED = 0,
    parameter int W_SIGNED = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s,
    output logic               ovf
);

    state_e             state_q;
    state_e             run_state;
    logic               mode_q;
    logic               cur_mode;
    logic               wloaded_q;
    logic [bw-1:0]      a_q;
    logic [bw-1:0]      b_q;
    logic [psum_bw-1:0] c_q;
    logic [psum_bw-1:0] acc_q;
    logic [psum_bw-1:0] drain_q;
    logic [2:0]         inst_e_q;
    logic               ovf_q;

    logic               ld, ex, dr, inst_active;
    logic               ws_sel;
    logic [bw-1:0]      mac_a, mac_b;
    logic [psum_bw-1:0] mac_c, mac_sum;
    logic               mac_ovf;
    logic [psum_bw-1:0] w_ext;

    assign ld          = inst_w[INST_LOAD];
    assign ex          = inst_w[INST_EXEC];
    assign dr          = inst_w[INST_DRAIN];
    assign inst_active = |inst_w;

    // In IDLE the live mode pin decides; afterwards the captured mode is authoritative.
    assign cur_mode = (state_q == IDLE) ? mode : mode_q;

    always_comb begin
        run_state = state_q;
        if (state_q == IDLE && inst_active) begin
            run_state = (cur_mode == MODE_OS) ? OS_RUN : WS_RUN;
        end
    end

    // The single multiply-add serves the WS psum in WS_RUN and the OS accumulator otherwise.
    assign ws_sel = (state_q == WS_RUN);
    assign mac_a  = ws_sel ? a_q : in_w;
    assign mac_b  = ws_sel ? b_q : in_n[bw-1:0];
    assign mac_c  = ws_sel ? c_q : acc_q;

    mac_unit #(
        .bw       (bw),
        .psum_bw  (psum_bw),
        .A_SIGNED (A_SIGNED),
        .W_SIGNED (W_SIGNED)
    ) u_mac (
        .a_i   (mac_a),
        .b_i   (mac_b),
        .c_i   (mac_c),
        .sum_o (mac_sum),
        .ovf_o (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_WS;
            wloaded_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            drain_q   <= '0;
            inst_e_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            inst_e_q[INST_EXEC]  <= ex;
            inst_e_q[INST_DRAIN] <= dr;
            // In WS the first load is swallowed as this tile's weight; later loads skip east.
            inst_e_q[INST_LOAD]  <= (cur_mode == MODE_WS) ? (ld & wloaded_q) : ld;

            if (state_q == IDLE && inst_active) begin
                mode_q <= mode;
            end
            state_q <= run_state;

            case (run_state)
                IDLE: ;
                WS_RUN: begin
                    if (ld && !wloaded_q) begin
                        b_q       <= in_w;
                        wloaded_q <= 1'b1;
                    end
                    if ((ld && wloaded_q) || ex) begin
                        a_q <= in_w;
                    end
                    if (ex) begin
                        c_q <= in_n;
                    end
                end
                OS_RUN: begin
                    if (dr) begin
                        drain_q <= acc_q;
                        acc_q   <= in_n;
                        state_q <= OS_DRAIN;
                    end else if (ex) begin
                        a_q   <= in_w;
                        b_q   <= in_n[bw-1:0];
                        acc_q <= mac_sum;
                        ovf_q <= ovf_q | mac_ovf;
                    end
                end
                OS_DRAIN: begin
                    if (!inst_active) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        drain_q <= '0;
                        ovf_q   <= 1'b0;
                    end else if (dr) begin
                        drain_q <= acc_q;
                        acc_q   <= in_n;
                    end
                end
            endcase
        end
    end

    assign w_ext = {{(psum_bw - bw){(W_SIGNED != 0) & b_q[bw-1]}}, b_q};

    always_comb begin
        out_s = '0;
        case (state_q)
            WS_RUN:   out_s = mac_sum;
            OS_RUN:   out_s = w_ext;
            OS_DRAIN: out_s = drain_q;
            default:  out_s = '0;
        endcase
    end

    assign out_e  = a_q;
    assign inst_e = inst_e_q;
    assign ovf    = ovf_q;

endmodule
